rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port among NREQ writeback requesters
//  (ALU, load unit, ...) using round-robin arbitration and a valid/ready handshake.
//  Drives the register file write port (WriteEn/WriteAddr/WriteData) from a registered
//  output stage. After reset it can sequence a clear of registers 1..31 before serving
//  requests. Sits between the writeback stage and the register file.
// PARAMETERS
//  NREQ        2  number of requesters (2..4)
//  INIT_CLEAR  1  1: run the INIT clear sequence after reset; 0: enter RUN directly
//  ZERO_RO     1  1: writes to address 0 are accepted but never reach the port
// PORTS
//  clk        in   1        clock; all state updates on the rising edge
//  rst_n      in   1        asynchronous, active-low reset
//  hold       in   1        stall from the controller; no grants while high
//  req_valid  in   NREQ     request i valid
//  req_addr   in   5*NREQ   request i destination register, slice [5i+4:5i]
//  req_data   in   32*NREQ  request i write data, slice [32i+31:32i]
//  req_ready  out  NREQ     grant to request i; transfer when valid&ready
//  wr_en      out  1        register-file WriteEn
//  wr_addr    out  5        register-file WriteAddr
//  wr_data    out  32       register-file WriteData
//  pend_mask  out  32       one-hot of wr_addr when wr_en=1, else 0 (hazard check)
//  init_done  out  1        high once the FSM is in RUN
// BEHAVIOUR
//  - Reset (rst_n=0, immediate): wr_en=0, wr_addr=0, wr_data=0, rr_ptr=0,
//    init_cnt=1, state=INIT if INIT_CLEAR else RUN; init_done=0 in INIT.
//  - FSM INIT: each cycle registers wr_en=1, wr_addr=init_cnt, wr_data=0, init_cnt++.
//    After the write of addr 31 is registered, the next state is RUN. 31 write cycles.
//    req_ready=0 throughout INIT. hold is ignored in INIT.
//  - FSM RUN: terminal until reset. init_done=1.
//  - Arbitration (combinational, RUN only): if hold=1 or no valid, req_ready=0.
//    Otherwise grant the first valid index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
//    At most one req_ready bit is high, and only for a valid requester.
//  - On a transfer by i: rr_ptr <= (i+1) mod NREQ. With no transfer, rr_ptr holds.
//  - Output stage, 1-cycle latency: on a transfer, wr_addr/wr_data <= granted addr/data,
//    and wr_en <= 1, except wr_en <= 0 when ZERO_RO=1 and the address is 0.
//    With no transfer, wr_en <= 0 and wr_addr/wr_data hold.
//  - A requester keeps valid/addr/data stable until it is accepted.
//  - Losers wait. No data is lost or duplicated.
//  - Two requesters targeting the same address are serialized in grant order;
//    the last grant wins in the register file.
//  - pend_mask is decoded combinationally from the registered wr_en/wr_addr.
//  - Fairness: with k requesters continuously valid, each is granted once every k transfers.
//  - Reset mid-INIT or mid-RUN: everything returns to reset values at once.
//    INIT restarts at addr 1.
// TESTING
//  1. Release reset, INIT_CLEAR=1 -> wr_en=1 for 31 cycles, addr 1..31, data 0.
//     init_done rises the cycle after addr 31. req_ready=0 throughout.
//  2. RUN, req0 valid addr=5 data=32'hDEADBEEF -> req_ready=01 that cycle; next cycle
//     wr_en=1, wr_addr=5, wr_data=DEADBEEF, pend_mask=32'h20; the following cycle wr_en=0.
//  3. Both valid for 6 cycles, addr 3/4 -> grant sequence 0,1,0,1,0,1;
//     wr_addr 3,4,3,4,3,4, each one cycle later.
//  4. req1 valid addr=0 data=1, ZERO_RO=1 -> req_ready=10, wr_en stays 0,
//     pend_mask=0, rr_ptr advances to 0.
//  5. hold=1 with both valid for 3 cycles -> req_ready=0 and wr_en=0.
//     After release, the grant goes to the requester rr_ptr indicated before hold.
//  6. rst_n=0 during INIT at init_cnt=10 -> wr_en=0 immediately.
//     After release, INIT restarts at wr_addr=1 and again runs 31 cycles.

Source files
------------

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_write_arbiter
// Description : Round-robin arbiter for the register-file write port, with a
//               registered output stage and an optional post-reset clear.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_write_arbiter #(
    parameter int NREQ       = 2,
    parameter int INIT_CLEAR = 1,
    parameter int ZERO_RO    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 hold,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 wr_en,
    output logic [4:0]           wr_addr,
    output logic [31:0]          wr_data,
    output logic [31:0]          pend_mask,
    output logic                 init_done
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam int                c_STATE_W = 1;
    localparam logic [c_STATE_W-1:0] c_INIT = 1'b0;
    localparam logic [c_STATE_W-1:0] c_RUN  = 1'b1;
    localparam logic [c_STATE_W-1:0] c_RESET_STATE = (INIT_CLEAR != 0) ? c_INIT : c_RUN;

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_nextState;
    logic [c_PTR_W-1:0]   r_rrPtr;
    logic [4:0]           r_initCnt;
    logic                 w_inRun;

    logic [4:0]           w_addrArr [NREQ];
    logic [31:0]          w_dataArr [NREQ];

    logic [NREQ-1:0]      w_grant;
    logic [c_PTR_W-1:0]   w_grantIdx;
    logic [c_PTR_W-1:0]   w_nextPtr;
    logic                 w_xfer;
    logic [4:0]           w_grantAddr;
    logic [31:0]          w_grantData;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_addrArr[gi] = req_addr[5*gi +: 5];
            assign w_dataArr[gi] = req_data[32*gi +: 32];
        end
    endgenerate

    // Index k positions after base, wrapped into 0..NREQ-1.
    function automatic logic [c_PTR_W-1:0] rotIdx(input logic [c_PTR_W-1:0] base, input int k);
        int s;
        s = 32'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return s[c_PTR_W-1:0];
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_RESET_STATE;
        else        r_state <= w_nextState;
    end

    // Next-state logic: INIT leaves once address 31 has been issued
    always_comb begin
        w_nextState = r_state;
        if (r_state == c_INIT && r_initCnt == 5'd31) w_nextState = c_RUN;
    end

    // Output decode
    always_comb begin
        w_inRun   = (r_state == c_RUN);
        init_done = w_inRun;
    end

    always_comb begin
        w_grant     = '0;
        w_grantIdx  = '0;
        w_grantAddr = '0;
        w_grantData = '0;
        w_xfer      = 1'b0;
        if (w_inRun && !hold) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!w_xfer && req_valid[rotIdx(r_rrPtr, k)]) begin
                    w_xfer      = 1'b1;
                    w_grantIdx  = rotIdx(r_rrPtr, k);
                end
            end
        end
        if (w_xfer) begin
            w_grant[w_grantIdx] = 1'b1;
            w_grantAddr         = w_addrArr[w_grantIdx];
            w_grantData         = w_dataArr[w_grantIdx];
        end
    end

    assign req_ready = w_grant;
    assign w_nextPtr = (w_grantIdx == c_PTR_W'(NREQ - 1)) ? '0 : w_grantIdx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            r_initCnt <= 5'd1;
            r_rrPtr   <= '0;
        end else if (r_state == c_INIT) begin
            wr_en     <= 1'b1;
            wr_addr   <= r_initCnt;
            wr_data   <= '0;
            r_initCnt <= r_initCnt + 5'd1;
        end else if (w_xfer) begin
            // Register 0 writes are consumed but never presented to the file
            wr_en   <= !((ZERO_RO != 0) && (w_grantAddr == 5'd0));
            wr_addr <= w_grantAddr;
            wr_data <= w_grantData;
            r_rrPtr <= w_nextPtr;
        end else begin
            wr_en <= 1'b0;
        end
    end

    always_comb begin
        pend_mask = '0;
        if (wr_en) pend_mask[wr_addr] = 1'b1;
    end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_write_arbiter
// Description : Self-checking bench: reference model, directed and random runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_write_arbiter;

    localparam int NREQ = 2;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                hold = 1'b0;
    logic [NREQ-1:0]     req_valid = '0;
    logic [5*NREQ-1:0]   req_addr = '0;
    logic [32*NREQ-1:0]  req_data = '0;
    logic [NREQ-1:0]     req_ready;
    logic                wr_en;
    logic [4:0]          wr_addr;
    logic [31:0]         wr_data;
    logic [31:0]         pend_mask;
    logic                init_done;

    rf_write_arbiter #(.NREQ(NREQ), .INIT_CLEAR(1), .ZERO_RO(1)) dut (
        .clk(clk), .rst_n(rst_n), .hold(hold),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .pend_mask(pend_mask), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nPass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: next address to clear (32 = running), pointer, port view, file
    int          mInit = 1;
    logic        mEn = 1'b0;
    logic [4:0]  mAddr = '0;
    logic [31:0] mData = '0;
    int          mPtr = 0;
    logic [31:0] mRf [32];
    logic [31:0] dRf [32];
    logic [NREQ-1:0] lastAcc = '0;

    function automatic int mGrant();
        int idx;
        if (mInit <= 31 || hold) return -1;
        for (int k = 0; k < NREQ; k++) begin
            idx = (mPtr + k) % NREQ;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int g;
        logic [4:0] a;
        if (!rst_n) begin
            mInit = 1; mEn = 1'b0; mAddr = '0; mData = '0; mPtr = 0;
        end else if (mInit <= 31) begin
            mEn = 1'b1; mAddr = 5'(mInit); mData = '0;
            mRf[mInit] = '0;
            mInit++;
        end else begin
            g = mGrant();
            if (g >= 0) begin
                a     = req_addr[5*g +: 5];
                mAddr = a;
                mData = req_data[32*g +: 32];
                mEn   = (a != 5'd0);
                if (a != 5'd0) mRf[a] = mData;
                mPtr  = (g + 1) % NREQ;
            end else begin
                mEn = 1'b0;
            end
        end
    end

    // Register file as seen through the write port
    always @(posedge clk) begin
        if (wr_en) dRf[wr_addr] = wr_data;
    end

    // Compare process: every cycle, sampled on the falling edge
    always @(negedge clk) begin
        int g;
        logic [NREQ-1:0] expReady;
        g = mGrant();
        expReady = (g >= 0) ? NREQ'(1 << g) : '0;
        check("model req_ready", 32'(req_ready), 32'(expReady));
        check("model wr_en", 32'(wr_en), 32'(mEn));
        check("model wr_addr", 32'(wr_addr), 32'(mAddr));
        check("model wr_data", wr_data, mData);
        check("model pend_mask", pend_mask, mEn ? (32'd1 << mAddr) : 32'd0);
        check("model init_done", 32'(init_done), 32'(mInit == 32));
        lastAcc = req_valid & req_ready;
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic setReq(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[5*i +: 5]  = a;
        req_data[32*i +: 32] = d;
    endtask

    // Release reset and follow the clear sequence for n cycles
    task automatic initSeq(input logic [NREQ-1:0] v, input int n);
        @(negedge clk); #2;
        rst_n = 1'b1;
        req_valid = v;
        for (int k = 1; k <= n; k++) begin
            tick();
            if (k == 31) req_valid = '0;
            @(negedge clk);
            check("init wr_en", 32'(wr_en), 32'd1);
            check("init wr_addr", 32'(wr_addr), 32'(k));
            check("init wr_data", wr_data, 32'd0);
            if (k < 31) check("init req_ready", 32'(req_ready), 32'd0);
            check("init init_done", 32'(init_done), 32'(k == 31));
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin mRf[i] = '0; dRf[i] = '0; end

        repeat (3) @(negedge clk);
        check("reset wr_en", 32'(wr_en), 32'd0);
        check("reset wr_addr", 32'(wr_addr), 32'd0);
        check("reset init_done", 32'(init_done), 32'd0);
        check("reset pend_mask", pend_mask, 32'd0);

        setReq(0, 5'd7, 32'h1111_1111);
        setReq(1, 5'd8, 32'h2222_2222);
        initSeq(2'b11, 31);
        tick();

        // Single requester, one-cycle latency
        tick(); req_valid = 2'b01; setReq(0, 5'd5, 32'hDEADBEEF);
        @(negedge clk); check("t2 req_ready", 32'(req_ready), 32'h1);
        tick(); req_valid = '0;
        @(negedge clk);
        check("t2 wr_en", 32'(wr_en), 32'd1);
        check("t2 wr_addr", 32'(wr_addr), 32'd5);
        check("t2 wr_data", wr_data, 32'hDEADBEEF);
        check("t2 pend_mask", pend_mask, 32'h20);
        tick(); @(negedge clk); check("t2 wr_en low", 32'(wr_en), 32'd0);

        // Write to register 0 is swallowed
        tick(); req_valid = 2'b10; setReq(1, 5'd0, 32'd1);
        @(negedge clk); check("t4 req_ready", 32'(req_ready), 32'h2);
        tick(); req_valid = '0;
        @(negedge clk);
        check("t4 wr_en", 32'(wr_en), 32'd0);
        check("t4 pend_mask", pend_mask, 32'd0);

        // Alternation with both continuously valid
        setReq(0, 5'd3, 32'hA0); setReq(1, 5'd4, 32'hB0);
        for (int k = 0; k < 6; k++) begin
            tick();
            req_valid = 2'b11;
            @(negedge clk);
            check("t3 grant", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k > 0) check("t3 wr_addr", 32'(wr_addr), ((k - 1) % 2 == 0) ? 32'd3 : 32'd4);
        end
        tick(); req_valid = '0;
        @(negedge clk); check("t3 last wr_addr", 32'(wr_addr), 32'd4);

        // Hold stalls grants; pointer position survives the stall
        tick(); hold = 1'b1; req_valid = 2'b11;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) tick();
            @(negedge clk);
            check("t5 hold ready", 32'(req_ready), 32'd0);
            check("t5 hold wr_en", 32'(wr_en), 32'd0);
        end
        tick(); hold = 1'b0;
        @(negedge clk); check("t5 release grant", 32'(req_ready), 32'h1);
        tick(); req_valid = '0;
        @(negedge clk); check("t5 wr_addr", 32'(wr_addr), 32'd3);

        // Reset in the middle of the clear sequence
        @(negedge clk); #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        initSeq('0, 9);
        #2 rst_n = 1'b0;
        #1;
        check("t6 async wr_en", 32'(wr_en), 32'd0);
        check("t6 async wr_addr", 32'(wr_addr), 32'd0);
        check("t6 async init_done", 32'(init_done), 32'd0);
        @(negedge clk);
        initSeq('0, 31);

        // Randomized traffic, small address range to force collisions
        for (int c = 0; c < 3000; c++) begin
            tick();
            hold = ($urandom_range(0, 9) == 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || lastAcc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    setReq(i, 5'($urandom_range(0, 7)), $urandom);
                end
            end
        end
        tick(); req_valid = '0; hold = 1'b0;
        repeat (3) @(negedge clk);
        for (int r = 1; r < 32; r++) check("regfile contents", dRf[r], mRf[r]);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
